rsa_binary_decrypt: RTL and testbench
=====================================

// Module: rsa_binary_decrypt
// PURPOSE
//  Binary (square-and-multiply) RSA decryption engine: plain = cipher^exp_d mod modulus.
//  Receive-side counterpart of the RSA_binary encrypt controller; same start/finished handshake.
//  Constant-time: fixed rounds, multiply always executed, committed only when exponent bit = 1.
//  Modular multiply is bit-serial interleaved shift-add-reduce; no hardware multiplier.
// PARAMETERS
//  W  8  operand width (cipher, exp_d, modulus, plain); W >= 2
// PORTS
//  clk      in   1  single clock, all state on rising edge
//  rst_n    in   1  synchronous active-low reset
//  start    in   1  request; sampled only while finished=1 (IDLE)
//  cipher   in   W  ciphertext; captured on accepted start
//  exp_d    in   W  private exponent; captured on accepted start
//  modulus  in   W  modulus n; captured on accepted start
//  finished out  1  1 = idle/ready (plain valid if a job ran); 0 = busy
//  plain    out  W  result, registered, held until next job completes
//  err      out  1  operand error flag, sticky until next accepted start or reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, finished=1, plain=0, err=0, counters=0. Aborts any job.
//  States: IDLE -> MUL -> SQR -> (MUL | DONE) -> IDLE. finished = (state==IDLE).
//  IDLE: start=1 at edge k -> latch operands; err<=0.
//   - modulus<2 or cipher>=modulus -> err<=1, stay IDLE, plain unchanged.
//   - else result<=1, base<=cipher, e<=exp_d, round<=0, bitcnt<=0, state<=MUL.
//  MUL: W cycles; t <= modmul(result, base), consumes base bits MSB first.
//   - after W cycles: result<=t if e[0]=1, else result unchanged; state<=SQR.
//  SQR: W cycles; base <= modmul(base, base).
//   - after W cycles: e<=e>>1; round==W-1 -> DONE, else round++, state<=MUL.
//  DONE: 1 cycle; plain<=result; state<=IDLE.
//  modmul step (one bit b of y per cycle, acc starts 0):
//   - acc=2*acc; if acc>=n acc-=n; if b acc+=x; if acc>=n acc-=n.
//   - internal width W+2; acc<n holds after every step.
//  Latency: finished low from edge k+1; at edge k+2*W*W+1 plain is valid and finished=1.
//   W=8: 129 busy cycles. Independent of exp_d value.
//  start while busy: ignored, no queueing. Input changes after capture: no effect.
//  start held high: a new job is accepted on the first cycle finished=1 (back-to-back allowed).
//  exp_d=0 -> plain=1. exp_d=1 -> plain=cipher.
//  rst_n low mid-job: job discarded; plain=0 on the next cycle.
// TESTING
//  W=8, n=33, d=3, cipher=29, start 1 cycle -> finished low 129 cycles, then plain=2, err=0
//  n=187, d=23, cipher=11 -> plain=88; repeat back-to-back with start held -> second plain=88, 1 idle cycle between
//  n=187, cipher=200 -> err=1 next cycle, finished stays 1, plain unchanged;
//   then n=1, cipher=0 -> err=1; then valid job -> err cleared at accept
//  d=0, n=187, cipher=50 -> plain=1; d=1 -> plain=50; both after exactly 129 busy cycles
//  start pulse at cycle 40 of a running job (n=33,d=3,c=29) -> ignored, result still 2 at cycle 129
//  rst_n low for 1 cycle at busy cycle 60 -> finished=1, plain=0, err=0 next cycle; new job completes correctly

Source files
------------

// File: rtl/rsa_binary_decrypt.sv
// Constant-time square-and-multiply RSA decryption: plain = cipher^exp_d mod modulus.
// Modular products use a bit-serial interleaved shift-add-reduce loop; no hardware multiplier.
module rsa_binary_decrypt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] cipher,
  input  logic [W-1:0] exp_d,
  input  logic [W-1:0] modulus,
  output logic         finished,
  output logic [W-1:0] plain,
  output logic         err
);

  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StMul, StSqr, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    e_q, e_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    plain_q, plain_d;
  logic            err_q, err_d;
  logic [CntW-1:0] round_q, round_d;
  logic [CntW-1:0] bitcnt_q, bitcnt_d;
  logic [W+1:0]    acc_q, acc_d;

  logic [W-1:0]    mul_x;
  logic [CntW-1:0] y_idx;
  logic            y_bit;
  logic [W+1:0]    n_ext, acc_dbl, acc_red, acc_add, acc_step;
  logic            bad_operands;

  // One modmul step; the multiplier bits come from base, MSB first, in both phases.
  always_comb begin
    mul_x    = (state_q == StSqr) ? base_q : result_q;
    y_idx    = LastCnt - bitcnt_q;
    y_bit    = base_q[y_idx];
    n_ext    = {2'b00, n_q};
    acc_dbl  = {acc_q[W:0], 1'b0};
    acc_red  = (acc_dbl >= n_ext) ? acc_dbl - n_ext : acc_dbl;
    acc_add  = acc_red + (y_bit ? {2'b00, mul_x} : '0);
    acc_step = (acc_add >= n_ext) ? acc_add - n_ext : acc_add;
  end

  assign bad_operands = (modulus < W'(2)) || (cipher >= modulus);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    base_d   = base_q;
    e_d      = e_q;
    n_d      = n_q;
    plain_d  = plain_q;
    err_d    = err_q;
    round_d  = round_q;
    bitcnt_d = bitcnt_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d   = modulus;
          err_d = bad_operands;
          if (!bad_operands) begin
            result_d = W'(1);
            base_d   = cipher;
            e_d      = exp_d;
            round_d  = '0;
            bitcnt_d = '0;
            acc_d    = '0;
            state_d  = StMul;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LastCnt) begin
          // Product always computed; only committed for a set exponent bit.
          if (e_q[0]) result_d = acc_step[W-1:0];
          acc_d    = '0;
          bitcnt_d = '0;
          state_d  = StSqr;
        end
      end
      StSqr: begin
        acc_d    = acc_step;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LastCnt) begin
          base_d   = acc_step[W-1:0];
          e_d      = e_q >> 1;
          acc_d    = '0;
          bitcnt_d = '0;
          if (round_q == LastCnt) begin
            state_d = StDone;
          end else begin
            round_d = round_q + 1'b1;
            state_d = StMul;
          end
        end
      end
      StDone: begin
        plain_d = result_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      base_q   <= '0;
      e_q      <= '0;
      n_q      <= '0;
      plain_q  <= '0;
      err_q    <= 1'b0;
      round_q  <= '0;
      bitcnt_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      base_q   <= base_d;
      e_q      <= e_d;
      n_q      <= n_d;
      plain_q  <= plain_d;
      err_q    <= err_d;
      round_q  <= round_d;
      bitcnt_q <= bitcnt_d;
      acc_q    <= acc_d;
    end
  end

  assign finished = (state_q == StIdle);
  assign plain    = plain_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rsa_binary_decrypt.sv
// Directed bench for rsa_binary_decrypt: vector table of jobs plus hand-written sequences for
// back-to-back starts, starts while busy and reset mid-job.
module tb_rsa_binary_decrypt;

  localparam int unsigned W = 8;
  localparam int Busy = 2 * W * W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] cipher, exp_d, modulus;
  logic         finished;
  logic [W-1:0] plain;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_binary_decrypt #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cipher   (cipher),
    .exp_d    (exp_d),
    .modulus  (modulus),
    .finished (finished),
    .plain    (plain),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic [W-1:0] p;    // expected plain (for error cases: value left from the previous job)
    logic         e;    // expected err
    int           busy; // expected busy cycles
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait, sampling at negedges, until finished rises; returns busy count (bounded).
  task automatic wait_done(input int already, output int busy);
    busy = already;
    while (!finished && busy < 1000) begin
      busy++;
      @(negedge clk);
    end
  endtask

  // One-cycle start pulse, then count busy negedges. err_acc is err just after the accept edge.
  task automatic run_job(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] c,
                         output int busy, output logic err_acc);
    @(negedge clk);
    modulus = n;
    exp_d   = d;
    cipher  = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    err_acc = err;
    wait_done(0, busy);
  endtask

  initial begin
    int   busy;
    int   idle;
    logic ea;

    vecs[0] = '{n: 8'd33,  d: 8'd3,   c: 8'd29,  p: 8'd2,   e: 1'b0, busy: Busy};
    vecs[1] = '{n: 8'd187, d: 8'd23,  c: 8'd11,  p: 8'd88,  e: 1'b0, busy: Busy};
    vecs[2] = '{n: 8'd187, d: 8'd23,  c: 8'd200, p: 8'd88,  e: 1'b1, busy: 0};
    vecs[3] = '{n: 8'd1,   d: 8'd5,   c: 8'd0,   p: 8'd88,  e: 1'b1, busy: 0};
    vecs[4] = '{n: 8'd187, d: 8'd0,   c: 8'd50,  p: 8'd1,   e: 1'b0, busy: Busy};
    vecs[5] = '{n: 8'd187, d: 8'd1,   c: 8'd50,  p: 8'd50,  e: 1'b0, busy: Busy};
    vecs[6] = '{n: 8'd33,  d: 8'd7,   c: 8'd2,   p: 8'd29,  e: 1'b0, busy: Busy};
    vecs[7] = '{n: 8'd255, d: 8'd2,   c: 8'd254, p: 8'd1,   e: 1'b0, busy: Busy};
    vecs[8] = '{n: 8'd187, d: 8'd7,   c: 8'd88,  p: 8'd11,  e: 1'b0, busy: Busy};
    vecs[9] = '{n: 8'd2,   d: 8'd255, c: 8'd1,   p: 8'd1,   e: 1'b0, busy: Busy};

    rst_n = 1'b0; start = 1'b0; cipher = '0; exp_d = '0; modulus = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_finished", 32'(finished), 32'd1);
    check("reset_plain", 32'(plain), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].n, vecs[i].d, vecs[i].c, busy, ea);
      check($sformatf("vec%0d_err_at_accept", i), 32'(ea), 32'(vecs[i].e));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_plain", i), 32'(plain), 32'(vecs[i].p));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e));
      if (vecs[i].e) begin
        repeat (3) @(negedge clk);
        check($sformatf("vec%0d_err_sticky", i), 32'(err), 32'd1);
        check($sformatf("vec%0d_idle", i), 32'(finished), 32'd1);
      end
    end

    // Back-to-back with start held high.
    @(negedge clk);
    modulus = 8'd187; exp_d = 8'd23; cipher = 8'd11; start = 1'b1;
    @(negedge clk);
    wait_done(0, busy);
    check("b2b_first_busy", 32'(busy), 32'(Busy));
    check("b2b_first_plain", 32'(plain), 32'd88);
    idle = 0;
    while (finished && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_idle_gap", 32'(idle), 32'd1);
    wait_done(0, busy);
    check("b2b_second_busy", 32'(busy), 32'(Busy));
    check("b2b_second_plain", 32'(plain), 32'd88);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    modulus = 8'd33; exp_d = 8'd3; cipher = 8'd29; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    modulus = 8'd187; exp_d = 8'd23; cipher = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, busy);
    check("busy_start_busy", 32'(busy), 32'(Busy));
    check("busy_start_plain", 32'(plain), 32'd2);
    repeat (2) @(negedge clk);
    check("busy_start_not_queued", 32'(finished), 32'd1);

    // Reset mid-job.
    @(negedge clk);
    modulus = 8'd33; exp_d = 8'd3; cipher = 8'd29; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    check("pre_reset_busy", 32'(finished), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_finished", 32'(finished), 32'd1);
    check("midrst_plain", 32'(plain), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    run_job(8'd187, 8'd23, 8'd11, busy, ea);
    check("post_rst_busy", 32'(busy), 32'(Busy));
    check("post_rst_plain", 32'(plain), 32'd88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
